// File: rtl/spdif_pkg.sv
// Shared S/PDIF definitions: preamble patterns, subframe slot map and the
// payload struct used by the encoder and the receive-side blocks.
package spdif_pkg;

  localparam int SF_AUDIO_W              = 20;
  localparam int SF_AUX_W                = 4;
  localparam int HALF_CELLS_PER_SUBFRAME = 64;

  // Preamble half-cell patterns for a line level of 0 before the preamble,
  // MSB is sent first. Inverted when the line sits at 1.
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  localparam int AUX_LSB   = 4;
  localparam int AUDIO_LSB = 8;
  localparam int SLOT_V    = 28;
  localparam int SLOT_U    = 29;
  localparam int SLOT_C    = 30;
  localparam int SLOT_P    = 31;

  // Packed MSB-first, so bit 0 is slot 4 and bit 27 is slot 31.
  typedef struct packed {
    logic                  p;
    logic                  c;
    logic                  u;
    logic                  v;
    logic [SF_AUDIO_W-1:0] audio;
    logic [SF_AUX_W-1:0]   aux;
  } subframe_t;

  // Even parity over slots 4..31: P makes the number of ones even.
  function automatic logic even_parity(input subframe_t s);
    return ^{s.c, s.u, s.v, s.audio, s.aux};
  endfunction

endpackage

// File: rtl/spdif_subframe_shifter.sv
// Subframe payload register.
//  i_clk/i_rst       half-cell clock, async active-high reset
//  i_load            load strobe (encoder ready)
//  i_valid           payload present; when low an underrun filler is loaded
//  i_audio/i_aux/i_v/i_u/i_c  payload fields
//  i_slot            slot number 0..31 to present on o_bit (slots 0..3 read 0)
//  o_bit             payload bit of i_slot
//  o_underrun        1-cycle pulse after a load with i_valid low
module spdif_subframe_shifter
  import spdif_pkg::*;
#(
  parameter int AUDIO_W = 20,
  parameter int AUX_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_valid,
  input  logic [AUDIO_W-1:0] i_audio,
  input  logic [AUX_W-1:0]   i_aux,
  input  logic               i_v,
  input  logic               i_u,
  input  logic               i_c,
  input  logic [4:0]         i_slot,
  output logic               o_bit,
  output logic               o_underrun
);

  subframe_t   w_pl;
  subframe_t   r_sf;
  logic        r_underrun;
  logic [31:0] w_slots;

  // Missing payload is replaced by a silent, invalid-flagged sample (V=1),
  // which forces P=1.
  always_comb begin
    w_pl = '0;
    if (i_valid) begin
      w_pl.audio = i_audio;
      w_pl.aux   = i_aux;
      w_pl.v     = i_v;
      w_pl.u     = i_u;
      w_pl.c     = i_c;
    end else begin
      w_pl.v = 1'b1;
    end
    w_pl.p = even_parity(w_pl);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sf       <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= i_load & ~i_valid;
      if (i_load) r_sf <= w_pl;
    end
  end

  // Pad the preamble slots so any 5-bit slot number is in range.
  assign w_slots    = {r_sf, 4'b0000};
  assign o_bit      = w_slots[i_slot];
  assign o_underrun = r_underrun;

endmodule

// File: rtl/spdif_bmc_encoder.sv
// S/PDIF transmit line encoder: one subframe payload per handshake in,
// biphase-mark line with B/M/W preambles out. One clock = one half-cell.
//  i_clk/i_rst        half-cell clock, async active-high reset
//  i_din_*            subframe payload, sampled only while o_din_ready
//  i_din_valid        payload present
//  o_din_ready        payload is loaded this cycle (last half-cell)
//  o_bmc_out          biphase-mark line
//  o_channel          channel of the subframe on the line (0=A, 1=B)
//  o_frame_count      frame index of the subframe on the line
//  o_block_start      first half-cell of frame 0, channel A
//  o_underrun         pulse when a ready cycle found no payload
module spdif_bmc_encoder
  import spdif_pkg::*;
#(
  parameter int FRAMES_PER_BLOCK = 192,
  parameter int AUDIO_W          = 20,
  parameter int AUX_W            = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [AUDIO_W-1:0] i_din_audio,
  input  logic [AUX_W-1:0]   i_din_aux,
  input  logic               i_din_v,
  input  logic               i_din_u,
  input  logic               i_din_c,
  input  logic               i_din_valid,
  output logic               o_din_ready,
  output logic               o_bmc_out,
  output logic               o_channel,
  output logic [7:0]         o_frame_count,
  output logic               o_block_start,
  output logic               o_underrun
);

  localparam logic [5:0] HC_LAST = 6'(HALF_CELLS_PER_SUBFRAME - 1);
  localparam logic [7:0] FC_LAST = 8'(FRAMES_PER_BLOCK - 1);

  logic [5:0] r_hc;
  logic       r_ch;
  logic [7:0] r_fc;
  logic       r_bmc;
  logic       r_lvl;

  logic       w_wrap;
  logic [5:0] w_hc_nxt;
  logic       w_ch_nxt;
  logic [7:0] w_fc_nxt;
  logic       w_lvl;
  logic [7:0] w_pre;
  logic       w_pre_bit;
  logic       w_slot_bit;
  logic       w_data_bit;
  logic       w_bmc_nxt;

  assign w_wrap   = (r_hc == HC_LAST);
  assign w_hc_nxt = r_hc + 6'd1;
  assign w_ch_nxt = w_wrap ? ~r_ch : r_ch;
  assign w_fc_nxt = (w_wrap && r_ch) ? ((r_fc == FC_LAST) ? 8'd0 : r_fc + 8'd1) : r_fc;

  // The line is registered, so everything below describes the half-cell
  // that starts at the next edge (w_hc_nxt, w_ch_nxt, w_fc_nxt).
  // Preamble polarity follows the level at the end of the previous subframe;
  // that level is captured into r_lvl at the wrap and reused for hc 1..7.
  assign w_lvl     = w_wrap ? r_bmc : r_lvl;
  assign w_pre     = w_ch_nxt ? PRE_W : ((w_fc_nxt == 8'd0) ? PRE_B : PRE_M);
  assign w_pre_bit = w_pre[~w_hc_nxt[2:0]] ^ w_lvl;

  // Even half-cell: mandatory cell-boundary transition; odd: mid-cell
  // transition only for a 1.
  assign w_data_bit = w_hc_nxt[0] ? (r_bmc ^ w_slot_bit) : ~r_bmc;
  assign w_bmc_nxt  = (w_hc_nxt[5:3] == 3'd0) ? w_pre_bit : w_data_bit;

  spdif_subframe_shifter #(
    .AUDIO_W (AUDIO_W),
    .AUX_W   (AUX_W)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_wrap),
    .i_valid    (i_din_valid),
    .i_audio    (i_din_audio),
    .i_aux      (i_din_aux),
    .i_v        (i_din_v),
    .i_u        (i_din_u),
    .i_c        (i_din_c),
    .i_slot     (w_hc_nxt[5:1]),
    .o_bit      (w_slot_bit),
    .o_underrun (o_underrun)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hc  <= HC_LAST;
      r_ch  <= 1'b1;
      r_fc  <= FC_LAST;
      r_bmc <= 1'b0;
      r_lvl <= 1'b0;
    end else begin
      r_hc  <= w_hc_nxt;
      r_ch  <= w_ch_nxt;
      r_fc  <= w_fc_nxt;
      r_bmc <= w_bmc_nxt;
      if (w_wrap) r_lvl <= r_bmc;
    end
  end

  assign o_din_ready   = w_wrap;
  assign o_bmc_out     = r_bmc;
  assign o_channel     = r_ch;
  assign o_frame_count = r_fc;
  assign o_block_start = (r_hc == 6'd0) && !r_ch && (r_fc == 8'd0);

endmodule

// File: tb/tb_spdif_bmc_encoder.sv
module tb_spdif_bmc_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] din_audio = '0;
  logic [3:0]  din_aux   = '0;
  logic        din_v = 1'b0, din_u = 1'b0, din_c = 1'b0, din_valid = 1'b0;
  logic        din_ready, bmc_out, channel, block_start, underrun;
  logic [7:0]  frame_count;

  int errors = 0;
  int checks = 0;

  spdif_bmc_encoder dut (
    .i_clk(clk), .i_rst(rst),
    .i_din_audio(din_audio), .i_din_aux(din_aux),
    .i_din_v(din_v), .i_din_u(din_u), .i_din_c(din_c), .i_din_valid(din_valid),
    .o_din_ready(din_ready), .o_bmc_out(bmc_out), .o_channel(channel),
    .o_frame_count(frame_count), .o_block_start(block_start), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] line;   // bit 63 = half-cell 0
    logic        ch;
    logic [7:0]  fc;
    logic        bs;
    logic        ur;
  } exp_t;

  exp_t sb[$];

  // bench-side stream state
  logic       m_ch  = 1'b1;
  logic [7:0] m_fc  = 8'd191;
  logic       m_lvl = 1'b0;
  int         n_sent = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] bmc_model(input logic [27:0] pl, input logic [7:0] pre,
                                            input logic lvl);
    logic [63:0] ln;
    logic        l;
    ln = '0;
    l  = lvl;
    for (int k = 0; k < 8; k++) begin
      l = pre[7-k] ^ lvl;
      ln[63-k] = l;
    end
    for (int k = 8; k < 64; k++) begin
      if (k % 2 == 0) l = ~l;
      else if (pl[(k/2)-4]) l = ~l;
      ln[63-k] = l;
    end
    return ln;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [19:0] a, input logic [3:0] x, input logic v, input logic u,
                      input logic c, input logic val, input bit hand_en, input logic [63:0] hand);
    bit          ok;
    exp_t        e;
    logic [27:0] pl;
    logic [7:0]  pre;
    int          ones;
    wait_ready(ok);
    if (!ok) return;
    din_audio = a; din_aux = x; din_v = v; din_u = u; din_c = c; din_valid = val;
    m_ch = ~m_ch;
    if (!m_ch) m_fc = (m_fc == 8'd191) ? 8'd0 : m_fc + 8'd1;
    if (!val) begin a = '0; x = '0; v = 1'b1; u = 1'b0; c = 1'b0; end
    pl = {1'b0, c, u, v, a, x};
    ones = 0;
    for (int i = 0; i < 27; i++) ones += int'(pl[i]);
    pl[27] = (ones % 2 == 1);
    pre = m_ch ? 8'hE4 : ((m_fc == 8'd0) ? 8'hE8 : 8'hE2);
    e.line = hand_en ? hand : bmc_model(pl, pre, m_lvl);
    m_lvl  = e.line[0];
    e.ch = m_ch; e.fc = m_fc; e.bs = (!m_ch && m_fc == 8'd0); e.ur = !val;
    sb.push_back(e);
    n_sent++;
    // scramble inputs away from the load cycle; the encoder must ignore them
    @(posedge clk); #1;
    din_audio = 20'($urandom); din_aux = 4'($urandom);
    din_v = 1'($urandom); din_u = 1'($urandom); din_c = 1'($urandom);
    din_valid = 1'($urandom);
  endtask

  // Monitor: collects 64 half-cells after every load and compares with the
  // head of the scoreboard.
  bit          collecting = 1'b0;
  int          col = 0;
  int          sf_idx = 0;
  logic [63:0] got_line;
  exp_t        cur;

  always @(negedge clk) begin
    if (rst) begin
      collecting = 1'b0;
      col = 0;
    end else begin
      if (collecting) begin
        if (col == 0) begin
          if (sb.size() == 0) begin
            collecting = 1'b0;
          end else begin
            cur = sb[0];
            chk("channel", 64'(channel), 64'(cur.ch));
            chk("frame_count", 64'(frame_count), 64'(cur.fc));
            chk("block_start", 64'(block_start), 64'(cur.bs));
            chk("underrun", 64'(underrun), 64'(cur.ur));
          end
        end
        if (collecting) begin
          got_line[63-col] = bmc_out;
          col++;
          if (col == 64) begin
            void'(sb.pop_front());
            chk($sformatf("line_sf%0d", sf_idx), got_line, cur.line);
            sf_idx++;
            collecting = 1'b0;
          end
        end
      end
      if (din_ready) begin
        collecting = 1'b1;
        col = 0;
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bmc", 64'(bmc_out), 64'd0);
    chk("rst_ready", 64'(din_ready), 64'd1);
    chk("rst_channel", 64'(channel), 64'd1);
    chk("rst_frame", 64'(frame_count), 64'd191);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_block_start", 64'(block_start), 64'd0);
    din_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // all-zero payload: B preamble then plain cell transitions
    send(20'h0, 4'h0, 0, 0, 0, 1, 1, 64'hE8CCCCCCCCCCCCCC);
    // audio LSB set: W preamble, mid-cell toggles at slots 8 and 31
    send(20'h1, 4'h0, 0, 0, 0, 1, 1, 64'hE4CCB33333333332);
    send(20'hFFFFF, 4'hF, 0, 1, 1, 1, 0, '0);
    send(20'hA5A5A, 4'h3, 1, 0, 1, 1, 0, '0);
    send(20'h12345, 4'h9, 0, 0, 0, 0, 0, '0);   // underrun
    send(20'h80000, 4'h1, 0, 0, 1, 1, 0, '0);
    // stream through a full block and past the frame wrap
    for (int i = 6; i < 388; i++)
      send(20'(i * 20'h1357), 4'(i), 1'(i >> 1), 1'(i >> 2), 1'(i >> 3), 1, 0, '0);

    // async reset part-way through a zero subframe (hc 29 is a high half-cell)
    send(20'h0, 4'h0, 0, 0, 0, 1, 0, '0);
    repeat (29) @(posedge clk);
    #3;
    chk("pre_rst_bmc", 64'(bmc_out), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_bmc", 64'(bmc_out), 64'd0);
    chk("async_rst_frame", 64'(frame_count), 64'd191);
    chk("async_rst_ready", 64'(din_ready), 64'd1);
    sb.delete();
    m_ch = 1'b1; m_fc = 8'd191; m_lvl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_underrun", 64'(underrun), 64'd0);
    din_valid = 1'b1;
    rst = 1'b0;
    send(20'h0, 4'h0, 0, 0, 0, 1, 1, 64'hE8CCCCCCCCCCCCCC);
    send(20'h1, 4'h0, 0, 0, 0, 1, 1, 64'hE4CCB33333333332);

    for (int i = 0; i < 300 && sb.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
